fl_addsub_pipe: RTL
===================

# fl_addsub_pipe

Pipelined, parametrised IEEE-754-style floating-point adder/subtractor. It is the clocked successor to the combinational 32-bit float adder in the lab datapath. It adds or subtracts two operands of configurable exponent and mantissa width, normalises the result with a leading-zero count, and rounds to nearest-even. Operands enter and results leave through valid/ready handshakes, and the block sits between the operand register file and the result writeback stage.

## Interface
- EXP_W, default 8, exponent field width (≥3).
- MAN_W, default 23, stored mantissa width (≥4); word width W = 1+EXP_W+MAN_W.
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block accepts operands this cycle.
- in0  in  W  operand A {sign, exp, man}.
- in1  in  W  operand B.
- sub  in  1  0: A+B, 1: A−B (B sign inverted at entry).
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- out  out  W  result.
- out_flags  out  4  {nan, inf, zero, inexact}.

## Operation
- Three pipeline stages, each with a valid bit.
- S1 (align):
  - Classify operands as zero, inf, NaN or normal; denormal inputs are flushed to zero (FTZ).
  - Swap so that the larger magnitude (exponent, then mantissa) goes to the big operand.
  - d = exp_big − exp_small.
  - Shift the small mantissa {1,man} right by d into MAN_W+4 bits with guard, round and sticky.
  - If d ≥ MAN_W+3, the whole small mantissa folds into sticky.
- S2 (add): effective subtract = sign_big ^ sign_small'.
  - Add case: big + small, MAN_W+5-bit result.
  - Subtract case: big − small. The result is never negative because of the S1 swap.
- S3 (normalise/round/pack):
  - Carry out: shift right 1, exp+1, and OR the shifted-out bit into sticky.
  - Otherwise: leading-zero count L, shift left L, exp−L.
  - Round to nearest-even on guard/round/sticky. A rounding carry renormalises (exp+1).
  - Result exponent ≥ 2^EXP_W−1: output ±inf, set inf and inexact.
  - Result exponent ≤ 0: output ±0 (FTZ), set zero and inexact.
- Special cases, resolved in S1 and carried as a bypass result:
  - Any NaN input, or inf + (−inf): canonical NaN {0, all-ones exp, man MSB 1, rest 0}, nan flag set.
  - inf ± finite: that inf, inf flag set.
  - x + (−x) with an exact zero result: +0.
  - (−0) + (−0): −0.
  - ±0 + y: y exactly, with no rounding.
- The zero flag is set whenever the output is ±0. The inexact flag is set when any of guard, round or sticky is nonzero, and on overflow or underflow.

## Timing
- Global advance: en = !out_valid || out_ready. All stage registers load only when en is high, and in_ready = en.
- Transfers:
  - An input transfer happens on in_valid && in_ready.
  - An output transfer happens on out_valid && out_ready.
- Latency: with out_ready held high, the result appears with out_valid high exactly 3 cycles after the accepting edge. Throughput is one result per cycle.
- Stall:
  - While out_valid && !out_ready, every stage holds, in_ready is low, and out, out_flags and out_valid stay stable.
  - Nothing is dropped or duplicated, and results are returned in order.
- Bubbles are not collapsed. An empty stage still advances only when en is high.
- Reset:
  - On the first edge with rst high, all stage valid bits and out_valid go to 0, out and out_flags go to 0, and in_ready goes to 1.
  - In-flight operations are discarded, including when rst is asserted mid-stream.
  - Inputs sampled in a reset cycle are ignored.
- Simultaneous accept and emit in the same cycle is legal and keeps the pipeline full.

## Test plan
- Basic add and latency: 3F800000 + 3F800000, sub=0, out_ready=1 → out=40000000, flags=0000, with out_valid 3 cycles after accept.
- Cancellation: 3F800000 − 3F800000 (sub=1) → 00000000, zero=1, inexact=0. Also 40400000 − 3FC00000 → 3FC00000.
- Rounding:
  - 3F800000 + 33800000 (a tie) → 3F800000, inexact=1.
  - 3F800000 + 34000000 → 3F800001, inexact=0.
- Specials:
  - 7F7FFFFF + 7F7FFFFF → 7F800000, inf=1, inexact=1.
  - 7F800000 + FF800000 → 7FC00000, nan=1.
  - 80000000 + 80000000 → 80000000.
- Backpressure: 4 back-to-back inputs with out_ready low for 5 cycles → in_ready drops, out is held stable, then 4 correct results in order with no loss.
- Reset mid-stream: assert rst with 3 operations in flight → out_valid=0 after the edge and no stale result ever emitted; the next input yields a correct result after 3 cycles.
- Parameter sweep: EXP_W=5, MAN_W=10 (half precision): 3C00 + 3C00 → 4000; 7BFF + 7BFF → 7C00 with inf=1.

Source files
------------

// File: rtl/fl_addsub_pipe.sv
// rtl/fl_addsub_pipe.sv - pipelined floating-point adder/subtractor, round-to-nearest-even, FTZ
//
// Purpose: adds or subtracts two {sign, exp, man} operands of width 1+EXP_W+MAN_W.
//   The datapath has three stages (align, add, normalise) and an output register
//   that does the rounding and packing, so a result leaves 3 cycles after the
//   operands are accepted.
//   All registers advance together on en = !out_valid || out_ready.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    operand handshake; in0 = A, in1 = B, sub selects A-B
//   out_valid/out_ready  result handshake; out = result
//   out_flags            {nan, inf, zero, inexact}
module fl_addsub_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [EXP_W+MAN_W:0] in0,
  input  logic [EXP_W+MAN_W:0] in1,
  input  logic                 sub,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MAN_W:0] out,
  output logic [3:0]           out_flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int FW = MAN_W + 4;   // {hidden, man, guard, round, sticky}
  localparam int XW = EXP_W + 8;   // exponent arithmetic width, sign bit at the top
  localparam logic [EXP_W-1:0] EMAX = '1;

  logic en;
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // ---------------- S1: classify, swap, align ----------------
  logic             sa, sb, za, zb, ia, ib, na, nb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] ma, mb;

  assign sa = in0[W-1];
  assign ea = in0[W-2:MAN_W];
  assign ma = in0[MAN_W-1:0];
  assign sb = in1[W-1] ^ sub;
  assign eb = in1[W-2:MAN_W];
  assign mb = in1[MAN_W-1:0];
  // A zero exponent covers true zeros and flushed denormals alike.
  assign za = (ea == '0);
  assign zb = (eb == '0);
  assign ia = (ea == EMAX) && (ma == '0);
  assign ib = (eb == EMAX) && (mb == '0);
  assign na = (ea == EMAX) && (ma != '0);
  assign nb = (eb == EMAX) && (mb != '0);

  logic             a_big, s_big, s_sml, byp1;
  logic [EXP_W-1:0] e_big, e_sml, d;
  logic [MAN_W-1:0] m_big, m_sml;
  logic [2*FW-1:0]  sh_wide;
  logic [FW-1:0]    big_ext, sml_ext;
  logic [W-1:0]     byp_val1;
  logic [3:0]       byp_flags1;

  always_comb begin
    a_big   = {ea, ma} >= {eb, mb};
    s_big   = a_big ? sa : sb;
    s_sml   = a_big ? sb : sa;
    e_big   = a_big ? ea : eb;
    e_sml   = a_big ? eb : ea;
    m_big   = a_big ? ma : mb;
    m_sml   = a_big ? mb : ma;
    d       = e_big - e_sml;
    big_ext = {1'b1, m_big, 3'b000};
    // Lower half of the wide shift collects every bit pushed past the sticky position.
    sh_wide = {1'b1, m_sml, 3'b000, {FW{1'b0}}} >> d;
    if (32'(d) >= 32'(FW - 1)) begin
      sml_ext = FW'(1);
    end else begin
      sml_ext = {sh_wide[2*FW-1:FW+1], sh_wide[FW] | (|sh_wide[FW-1:0])};
    end

    byp1       = 1'b1;
    byp_val1   = '0;
    byp_flags1 = 4'b0000;
    if (na || nb || (ia && ib && (sa != sb))) begin
      byp_val1   = {1'b0, EMAX, 1'b1, {(MAN_W-1){1'b0}}};
      byp_flags1 = 4'b1000;
    end else if (ia) begin
      byp_val1   = {sa, EMAX, {MAN_W{1'b0}}};
      byp_flags1 = 4'b0100;
    end else if (ib) begin
      byp_val1   = {sb, EMAX, {MAN_W{1'b0}}};
      byp_flags1 = 4'b0100;
    end else if (za && zb) begin
      // Only (-0) + (-0) keeps a negative sign.
      byp_val1   = {sa & sb, {(W-1){1'b0}}};
      byp_flags1 = 4'b0010;
    end else if (za) begin
      byp_val1   = {sb, eb, mb};
    end else if (zb) begin
      byp_val1   = {sa, ea, ma};
    end else begin
      byp1       = 1'b0;
    end
  end

  logic             v1, r1_byp, r1_sign, r1_sub;
  logic [W-1:0]     r1_byp_val;
  logic [3:0]       r1_byp_flags;
  logic [EXP_W-1:0] r1_exp;
  logic [FW-1:0]    r1_big, r1_sml;

  always_ff @(posedge clk) begin
    if (en) begin
      r1_byp       <= byp1;
      r1_byp_val   <= byp_val1;
      r1_byp_flags <= byp_flags1;
      r1_sign      <= s_big;
      r1_sub       <= s_big ^ s_sml;
      r1_exp       <= e_big;
      r1_big       <= big_ext;
      r1_sml       <= sml_ext;
    end
  end

  // ---------------- S2: add / subtract magnitudes ----------------
  logic [FW:0] sum2;
  // The swap guarantees big >= small, so the difference never goes negative.
  assign sum2 = r1_sub ? ({1'b0, r1_big} - {1'b0, r1_sml})
                       : ({1'b0, r1_big} + {1'b0, r1_sml});

  logic             v2, r2_byp, r2_sign;
  logic [W-1:0]     r2_byp_val;
  logic [3:0]       r2_byp_flags;
  logic [EXP_W-1:0] r2_exp;
  logic [FW:0]      r2_sum;

  always_ff @(posedge clk) begin
    if (en) begin
      r2_byp       <= r1_byp;
      r2_byp_val   <= r1_byp_val;
      r2_byp_flags <= r1_byp_flags;
      r2_sign      <= r1_sign;
      r2_exp       <= r1_exp;
      r2_sum       <= sum2;
    end
  end

  // ---------------- S3: normalise ----------------
  logic [XW-1:0] lz, x3, ext_exp;
  logic [FW-1:0] n3;
  logic          found, z3;

  assign ext_exp = {{(XW-EXP_W){1'b0}}, r2_exp};

  always_comb begin
    lz    = XW'(FW);
    found = 1'b0;
    for (int i = FW - 1; i >= 0; i--) begin
      if (!found && r2_sum[i]) begin
        lz    = XW'(FW - 1 - i);
        found = 1'b1;
      end
    end
    // A large left shift only follows near-total cancellation (d <= 1), where
    // round and sticky are still zero, so shifting them up is exact.
    if (r2_sum[FW]) begin
      n3 = {r2_sum[FW:2], r2_sum[1] | r2_sum[0]};
      x3 = ext_exp + XW'(1);
    end else begin
      n3 = r2_sum[FW-1:0] << lz;
      x3 = ext_exp - lz;
    end
    z3 = (r2_sum == '0);
  end

  logic          v3, r3_byp, r3_sign, r3_zero;
  logic [W-1:0]  r3_byp_val;
  logic [3:0]    r3_byp_flags;
  logic [XW-1:0] r3_exp;
  logic [FW-1:0] r3_n;

  always_ff @(posedge clk) begin
    if (en) begin
      r3_byp       <= r2_byp;
      r3_byp_val   <= r2_byp_val;
      r3_byp_flags <= r2_byp_flags;
      r3_sign      <= r2_sign;
      r3_zero      <= z3;
      r3_exp       <= x3;
      r3_n         <= n3;
    end
  end

  // ---------------- round and pack into the output register ----------------
  logic             up, inex, ovf, unf;
  logic [MAN_W+1:0] mr;
  logic [MAN_W-1:0] man_f;
  logic [XW-1:0]    xr;
  logic [W-1:0]     res;
  logic [3:0]       flg;

  always_comb begin
    inex  = r3_n[2] | r3_n[1] | r3_n[0];
    up    = r3_n[2] & (r3_n[1] | r3_n[0] | r3_n[3]);
    mr    = {1'b0, r3_n[FW-1:3]} + (MAN_W+2)'(up);
    // A rounding carry leaves 10...0, so the stored mantissa becomes zero.
    xr    = r3_exp + XW'(mr[MAN_W+1]);
    man_f = mr[MAN_W+1] ? mr[MAN_W:1] : mr[MAN_W-1:0];
    ovf   = !xr[XW-1] && (xr >= XW'(EMAX));
    unf   = xr[XW-1] || (xr == '0);
    res   = {r3_sign, xr[EXP_W-1:0], man_f};
    flg   = {3'b000, inex};
    if (r3_byp) begin
      res = r3_byp_val;
      flg = r3_byp_flags;
    end else if (r3_zero) begin
      res = '0;
      flg = 4'b0010;
    end else if (ovf) begin
      res = {r3_sign, EMAX, {MAN_W{1'b0}}};
      flg = 4'b0101;
    end else if (unf) begin
      res = {r3_sign, {(W-1){1'b0}}};
      flg = 4'b0011;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      v2        <= 1'b0;
      v3        <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      out_flags <= '0;
    end else if (en) begin
      v1        <= in_valid;
      v2        <= v1;
      v3        <= v2;
      out_valid <= v3;
      if (v3) begin
        out       <= res;
        out_flags <= flg;
      end
    end
  end
endmodule
